// File: rtl/mem_bus_pkg.sv
// Shared definitions for the word-copy engine and its native memory bus.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0]  WSTRB_READ = 4'h0;
  localparam logic [3:0]  WSTRB_WORD = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

  // Byte address of word idx past base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/mem_dma_if.sv
// Native valid/ready memory bus as seen from one initiator.
// Handshake: the initiator holds mem_valid with stable addr/wdata/wstrb until the
// cycle mem_ready=1; that cycle completes the transfer and mem_rdata is valid in it.
interface mem_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_dma.sv
// Word-granular copy engine: alternates one read and one write per word,
// with a per-transaction bus timeout. Every output comes straight from a flop.
import mem_bus_pkg::*;

module mem_dma #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  output state_t               state_dbg,
  mem_dma_if.master            bus
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [31:0]          src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, words_done_q, words_done_d, wd_next;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                 valid_q, valid_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      words_done_q <= '0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= WSTRB_READ;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      words_done_q <= words_done_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    words_done_d = words_done_q;
    wd_next      = words_done_q + 1'b1;
    tmo_d        = tmo_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = src_addr & 32'hFFFF_FFFC;
          dst_d        = dst_addr & 32'hFFFF_FFFC;
          len_d        = len_words;
          words_done_d = '0;
          error_d      = 1'b0;
          tmo_d        = '0;
          if (len_words == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            addr_d  = src_addr & 32'hFFFF_FFFC;
            wstrb_d = WSTRB_READ;
          end
        end
      end

      READ, WRITE: begin
        if (bus.mem_ready) begin
          // Each new transaction restarts its own timeout window.
          tmo_d = '0;
          if (state_q == READ) begin
            state_d = WRITE;
            addr_d  = word_addr(dst_q, 32'(words_done_q));
            wdata_d = bus.mem_rdata;
            wstrb_d = WSTRB_WORD;
          end else begin
            words_done_d = wd_next;
            if (wd_next == len_q) begin
              state_d = FINISH;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              wstrb_d = WSTRB_READ;
            end else begin
              state_d = READ;
              addr_d  = word_addr(src_q, 32'(wd_next));
              wstrb_d = WSTRB_READ;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = FINISH;
          error_d = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          wstrb_d = WSTRB_READ;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_done    = words_done_q;
  assign state_dbg     = state_q;
  assign bus.mem_valid = valid_q;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: table of copy jobs plus hand-written timeout and
// start/reset sequences, with a transaction scoreboard on the bus.
`timescale 1ns/1ps
module tb_mem_dma;
  import mem_bus_pkg::*;

  localparam int LW  = 16;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [31:0]   src_addr = '0, dst_addr = '0;
  logic [LW-1:0] len_words = '0;
  logic          busy, done, error;
  logic [LW-1:0] words_done;
  state_t        state_dbg;

  mem_dma_if bus_if ();

  mem_dma #(.TIMEOUT_CYCLES(TMO), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len_words  (len_words),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .state_dbg  (state_dbg),
    .bus        (bus_if)
  );

  // ---------------- memory responder ----------------
  logic [31:0] rd_mem [logic [31:0]];
  logic [31:0] wr_mem [logic [31:0]];
  int max_wait = 0;
  int hang_txn = -1;
  int wait_cnt;
  int txn_cnt;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (rd_mem.exists(a)) return rd_mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_if.mem_ready <= 1'b0;
      bus_if.mem_rdata <= '0;
      wait_cnt         <= 0;
      txn_cnt          <= 0;
    end else begin
      if (bus_if.mem_ready) begin
        bus_if.mem_ready <= 1'b0;
        if (bus_if.mem_wstrb == WSTRB_WORD) wr_mem[bus_if.mem_addr] = bus_if.mem_wdata;
        txn_cnt <= txn_cnt + 1;
      end else if (bus_if.mem_valid && txn_cnt != hang_txn) begin
        if (wait_cnt == 0) begin
          bus_if.mem_ready <= 1'b1;
          bus_if.mem_rdata <= model_rd(bus_if.mem_addr);
          wait_cnt         <= int'($urandom_range(32'(max_wait), 0));
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end
      if (start) begin
        txn_cnt  <= 0;
        wait_cnt <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [67:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_seen, busy_seen, stall, max_stall, unstable, sb_extra;
  logic        prev_valid, prev_ready;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    exp_q.delete();
    valid_seen = 0; busy_seen = 0; stall = 0; max_stall = 0;
    unstable = 0; sb_extra = 0; prev_valid = 1'b0; prev_ready = 1'b0;
    prev_addr = '0; prev_wdata = '0; prev_wstrb = '0;
  endtask

  task automatic push_job(input logic [31:0] s, input logic [31:0] d, input int len, input int n_exp);
    for (int i = 0; i < len; i++) begin
      if (exp_q.size() < n_exp) exp_q.push_back({s + 32'(i * 4), WSTRB_READ, 32'h0});
      if (exp_q.size() < n_exp) exp_q.push_back({d + 32'(i * 4), WSTRB_WORD, model_rd(s + 32'(i * 4))});
    end
  endtask

  // Called once per cycle, #1 after the rising edge.
  task automatic sample_cycle();
    logic [67:0] e;
    if (bus_if.mem_valid) valid_seen++;
    if (busy) busy_seen++;
    if (bus_if.mem_valid && !bus_if.mem_ready) begin
      stall++;
      if (stall > max_stall) max_stall = stall;
    end else begin
      stall = 0;
    end
    if (prev_valid && !prev_ready && bus_if.mem_valid &&
        (bus_if.mem_addr !== prev_addr || bus_if.mem_wdata !== prev_wdata ||
         bus_if.mem_wstrb !== prev_wstrb)) unstable++;
    prev_valid = bus_if.mem_valid;  prev_ready = bus_if.mem_ready;
    prev_addr  = bus_if.mem_addr;   prev_wdata = bus_if.mem_wdata;
    prev_wstrb = bus_if.mem_wstrb;
    if (bus_if.mem_valid && bus_if.mem_ready) begin
      if (exp_q.size() == 0) begin
        sb_extra++;
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", bus_if.mem_addr, e[67:36]);
        check("sb_wstrb", 32'(bus_if.mem_wstrb), 32'(e[35:32]));
        if (e[35:32] == WSTRB_WORD) check("sb_wdata", bus_if.mem_wdata, e[31:0]);
      end
    end
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int mw, input int hang, input int exp_done,
                          input int exp_words, input int exp_err, input int exp_stall);
    logic [31:0] s, d, got;
    int done_cyc;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    clear_obs();
    max_wait = mw;
    hang_txn = hang;
    push_job(s, d, len, (hang >= 0) ? hang : 2 * len);
    start = 1'b1; src_addr = src; dst_addr = dst; len_words = LW'(len);
    tick();
    start = 1'b0;
    check({"busy_c1_", tag}, 32'(busy), 32'(len != 0));
    check({"valid_c1_", tag}, 32'(bus_if.mem_valid), 32'(len != 0));
    done_cyc = -1;
    for (int c = 1; c < 600; c++) begin
      sample_cycle();
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    if (exp_done >= 0) check({"done_cycle_", tag}, 32'(done_cyc), 32'(exp_done));
    else check({"done_seen_", tag}, 32'(done_cyc > 0), 32'd1);
    check({"busy_at_done_", tag}, 32'(busy), 32'd0);
    check({"valid_at_done_", tag}, 32'(bus_if.mem_valid), 32'd0);
    check({"words_done_", tag}, 32'(words_done), 32'(exp_words));
    check({"error_", tag}, 32'(error), 32'(exp_err));
    check({"sb_left_", tag}, 32'(exp_q.size()), 32'd0);
    check({"sb_extra_", tag}, 32'(sb_extra), 32'd0);
    check({"stable_", tag}, 32'(unstable), 32'd0);
    if (exp_stall >= 0) check({"stall_", tag}, 32'(max_stall), 32'(exp_stall));
    if (len == 0) begin
      check({"no_valid_", tag}, 32'(valid_seen), 32'd0);
      check({"no_busy_", tag}, 32'(busy_seen), 32'd0);
    end
    for (int i = 0; i < exp_words; i++) begin
      got = wr_mem.exists(d + 32'(i * 4)) ? wr_mem[d + 32'(i * 4)] : 32'hxxxx_xxxx;
      check({"dst_word_", tag}, got, model_rd(s + 32'(i * 4)));
    end
    tick();
    check({"done_pulse_", tag}, 32'(done), 32'd0);
    check({"error_hold_", tag}, 32'(error), 32'(exp_err));
    tick();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    string       tag;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          mw;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];
  int   done_after;

  initial begin
    vecs[0] = '{"basic4",  32'h0001_0000, 32'h0001_0100, 4, 0, 17};
    vecs[1] = '{"len0",    32'h0000_2000, 32'h0000_3000, 0, 0, 1};
    vecs[2] = '{"wait8",   32'h0002_0000, 32'h0002_0400, 8, 3, -1};
    vecs[3] = '{"srcwrap", 32'hFFFF_FFF8, 32'h0003_0000, 4, 0, 17};
    vecs[4] = '{"unalign", 32'h0004_0003, 32'h0004_0102, 2, 0, 9};
    vecs[5] = '{"dstwrap", 32'h0005_0000, 32'hFFFF_FFFC, 3, 1, -1};

    rd_mem[32'h0001_0000] = 32'h1111_1111;
    rd_mem[32'h0001_0004] = 32'h2222_2222;
    rd_mem[32'h0001_0008] = 32'h3333_3333;
    rd_mem[32'h0001_000C] = 32'h4444_4444;

    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_done), 32'd0);
    check("rst_valid", 32'(bus_if.mem_valid), 32'd0);
    check("rst_addr", bus_if.mem_addr, 32'd0);
    check("rst_wstrb", 32'(bus_if.mem_wstrb), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++)
      run_xfer(vecs[v].tag, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].mw, -1,
               vecs[v].exp_done, vecs[v].len, 0, -1);
    check("mem_instr", 32'(bus_if.mem_instr), 32'd0);

    // Third transaction never answered: valid held TMO cycles, then abort.
    run_xfer("timeout", 32'h0006_0000, 32'h0006_0100, 4, 0, 2, 21, 1, 1, TMO);
    // Next accepted start clears the sticky error.
    run_xfer("errclr", 32'h0006_0000, 32'h0006_0100, 0, 0, -1, 1, 0, 0, -1);

    // Second start mid-transfer is ignored; reset mid-transfer aborts silently.
    clear_obs();
    max_wait = 0;
    hang_txn = -1;
    push_job(32'h0007_0000, 32'h0007_0100, 8, 16);
    start = 1'b1; src_addr = 32'h0007_0000; dst_addr = 32'h0007_0100; len_words = LW'(8);
    tick();
    start = 1'b0;
    done_after = 0;
    for (int c = 1; c <= 10; c++) begin
      sample_cycle();
      if (done) done_after++;
      if (c == 3) begin
        start = 1'b1; src_addr = 32'h0008_0000; dst_addr = 32'h0008_0100; len_words = LW'(1);
      end else begin
        start = 1'b0;
      end
      if (c < 10) tick();
    end
    check("restart_no_done", 32'(done_after), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("wd_pre_rst", 32'(words_done), 32'd2);
    check("sb_extra_restart", 32'(sb_extra), 32'd0);
    check("stable_restart", 32'(unstable), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_valid", 32'(bus_if.mem_valid), 32'd0);
    check("arst_words", 32'(words_done), 32'd0);
    check("arst_addr", bus_if.mem_addr, 32'd0);
    check("arst_wdata", bus_if.mem_wdata, 32'd0);
    check("arst_wstrb", 32'(bus_if.mem_wstrb), 32'd0);
    check("arst_state", 32'(state_dbg), 32'(IDLE));
    exp_q.delete();
    tick();
    rst = 1'b0;
    done_after = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done || busy || bus_if.mem_valid) done_after++;
    end
    check("post_rst_quiet", 32'(done_after), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Word-granular copy engine that initiates transactions on the native valid/ready memory bus (mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata, mem_instr). On a start pulse it copies len_words 32-bit words from src_addr to dst_addr with alternating read and write transactions. It sits as a bus initiator in front of the SoC memory, arbitrated externally against the CPU port. It reports completion, progress and a bus-timeout error.

## Interface
- TIMEOUT_CYCLES, 1024: cycles mem_valid may stay high without mem_ready before the transfer aborts (≥1).
- LEN_WIDTH, 16: width of the length and progress counters.

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len_words  in  LEN_WIDTH  number of words to copy; 0 allowed
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse (success or error)
- error  out  1  timeout flag; held until next accepted start
- words_done  out  LEN_WIDTH  words fully written in the current/last transfer
- mem_valid  out  1  transaction request
- mem_instr  out  1  constant 0
- mem_ready  in  1  responder completion strobe
- mem_addr  out  32  word-aligned transaction address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b0000 read, 4'b1111 write
- mem_rdata  in  32  read data, valid when mem_ready high

## Operation
- States: IDLE, READ, WRITE, FINISH. All outputs registered.
- IDLE: start=1 latches src/dst (low bits cleared), len, clears words_done and error. If len_words=0 -> FINISH; else -> READ.
- READ: mem_valid=1, mem_addr=src+4*i, mem_wstrb=0. On mem_ready: capture mem_rdata into data register -> WRITE.
- WRITE: mem_valid=1, mem_addr=dst+4*i, mem_wdata=data register, mem_wstrb=4'hF. On mem_ready: words_done+1, i+1; if i+1==len -> FINISH, else -> READ.
- FINISH: mem_valid=0, done=1 for one cycle, busy=0 -> IDLE.
- Address arithmetic is 32-bit modulo; wrap past 0xFFFFFFFC continues at 0x00000000.
- Overlapping src/dst ranges are not detected; copy is strictly ascending.
- start while busy is ignored, no side effects.
- Timeout: per-transaction counter cleared when a transaction is first presented, increments each cycle mem_valid=1 and mem_ready=0. Reaching TIMEOUT_CYCLES -> error=1, mem_valid=0, -> FINISH. words_done keeps the count of completed writes.
- mem_ready while mem_valid=0 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-transfer aborts immediately, no done pulse.
- start at cycle 0 -> busy=1 and mem_valid=1 (first READ) at cycle 1.
- Address, wdata and wstrb stay stable while mem_valid=1 until the cycle mem_ready=1.
- Transaction completes in the cycle mem_ready=1. The next transaction's address/strobe is presented the following cycle. mem_valid stays high across back-to-back transactions; the responder must not re-assert ready in consecutive cycles.
- With a responder asserting ready one cycle after valid: 2 cycles per transaction, 4 per word. Final write ready at cycle 4N, done=1 and busy=0 at cycle 4N+1.
- len_words=0: done pulse at cycle 1, no bus activity, busy stays 0.

## Structure
- Shared package mem_bus_pkg: state enum (IDLE, READ, WRITE, FINISH), WSTRB_READ=4'h0, WSTRB_WORD=4'hF, WORD_BYTES=4.
- Single module; no sub-module. Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Zero-wait memory model with src=0x10000 holding 0x11111111..0x44444444, dst=0x10100, len=4 -> dst words match; done at cycle 17; words_done=4; error=0.
- len=0 -> done pulse at cycle 1, mem_valid never high, busy stays 0.
- Responder with 3-cycle random wait states, len=8 -> mem_addr/mem_wdata/mem_wstrb stable while waiting; correct copy; 8 reads interleaved with 8 writes.
- Responder never asserts ready on the 3rd transaction, TIMEOUT_CYCLES=16 -> mem_valid drops after 16 cycles; error=1; done pulse; words_done=1.
- src=0xFFFFFFF8, len=4 -> reads 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- start re-pulsed mid-transfer, then reset asserted mid-transfer -> second start ignored; on reset all outputs 0 at once and no done pulse.
